uart_cmd_wrapper: RTL and testbench
===================================

# uart_cmd_wrapper

Packet layer around the UART transceiver pair. Assembles three received bytes (command, data high, data low) into one 24-bit command and hands it to the command processor with a ready/clear handshake. Also transmits single-byte responses back to the remote host on request. Sits between the serial pins and the command-processing logic of the quadcopter.

## Interface
- TIMEOUT_CLKS, default 100000: maximum inter-byte gap, in clk cycles, before a partial packet is discarded.
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- RX  in  1  serial input from host (idle high)
- TX  out  1  serial output to host (idle high)
- cmd  out  8  command byte of last complete packet
- data  out  16  {data_hi, data_lo} of last complete packet
- cmd_rdy  out  1  complete packet available
- clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy
- resp  in  8  response byte to send
- send_resp  in  1  one-cycle request to transmit resp
- resp_sent  out  1  set when response byte finished, cleared on next accepted send_resp

## Operation
- Instantiates UART_rcv and UART_tx. Byte captured on UART_rcv rdy; wrapper pulses clr_rdy the same cycle.
- RX FSM states: WAIT_CMD, WAIT_HI, WAIT_LO.
  - WAIT_CMD + rdy: shadow cmd <= rx_data, -> WAIT_HI.
  - WAIT_HI + rdy: shadow hi <= rx_data, -> WAIT_LO.
  - WAIT_LO + rdy: cmd/data outputs loaded atomically from shadow + rx_data, cmd_rdy set, -> WAIT_CMD.
- cmd/data outputs change only on packet completion; partial packets never visible.
- cmd_rdy cleared by clr_cmd_rdy or by the first byte of the next packet arriving. Completion and clr_cmd_rdy in same cycle: set wins.
- Gap counter: clears on every captured byte; counts only in WAIT_HI/WAIT_LO; reaching TIMEOUT_CLKS returns FSM to WAIT_CMD, discarding shadow bytes. cmd_rdy/cmd/data unaffected.
- TX FSM states: TX_IDLE, TX_BUSY. TX_IDLE + send_resp: pulse trmt with tx_data = resp, clear resp_sent, -> TX_BUSY. TX_BUSY + tx_done: set resp_sent, -> TX_IDLE. send_resp in TX_BUSY ignored (no queue).
- RX and TX paths independent; full-duplex operation permitted.

## Timing
- Reset values: TX = 1, cmd = 8'h00, data = 16'h0000, cmd_rdy = 0, resp_sent = 0; both FSMs in initial state, gap counter 0.
- Reset mid-packet or mid-transmission aborts immediately; TX returns high asynchronously.
- cmd_rdy rises one clk after the cycle UART_rcv rdy is high for the third byte.
- trmt asserted exactly one cycle, the cycle after send_resp is sampled.
- resp_sent rises one clk after tx_done.
- Gap counter width: clog2(TIMEOUT_CLKS+1); timeout fires on the cycle count equals TIMEOUT_CLKS, no wrap.

## Structure
- Shared package: RX state enum (WAIT_CMD, WAIT_HI, WAIT_LO), TX state enum (TX_IDLE, TX_BUSY), packet length constant (3 bytes).
- One sub-module natural: uart_pkt_assembler (RX FSM, shadow registers, gap counter); TX sequencing stays in the top.
- UART_tx and UART_rcv reused unchanged.

## Test plan
- Loop TX back to RX via a second UART_tx driven by the bench: send 8'hA5, 8'h12, 8'h34 -> cmd_rdy, cmd = 8'hA5, data = 16'h1234; clr_cmd_rdy -> cmd_rdy low next cycle.
- Send 8'h01, 8'hFF, then idle > TIMEOUT_CLKS, then 8'h02, 8'h00, 8'h07 -> single cmd_rdy with cmd = 8'h02, data = 16'h0007.
- Two back-to-back packets without clr_cmd_rdy: cmd_rdy drops on first byte of second packet, rises with second packet's values.
- send_resp with resp = 8'h5A -> TX frame decodes to 8'h5A, resp_sent high after tx_done; second send_resp while busy -> no extra frame.
- Assert rst_n low mid-packet after two bytes -> all outputs at reset values; next three bytes 8'h10, 8'h00, 8'h01 produce cmd = 8'h10, data = 16'h0001.
- Simultaneous packet completion and clr_cmd_rdy -> cmd_rdy remains high.

Source files
------------

// File: rtl/uart_cmd_wrapper_pkg.sv
// uart_cmd_wrapper shared types
// RX/TX sequencing states and packet geometry
package uart_cmd_wrapper_pkg;

  typedef enum logic [1:0] {
    WAIT_CMD,
    WAIT_HI,
    WAIT_LO
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

  localparam int PKT_LEN = 3;

endpackage

// File: rtl/uart_cmd_wrapper_if.sv
// uart_cmd_wrapper host-side interface
// command handoff and response request handshakes
interface uart_cmd_wrapper_if;

  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport master (
    output cmd,
    output data,
    output cmd_rdy,
    output resp_sent,
    input  clr_cmd_rdy,
    input  resp,
    input  send_resp
  );

  modport slave (
    input  cmd,
    input  data,
    input  cmd_rdy,
    input  resp_sent,
    output clr_cmd_rdy,
    output resp,
    output send_resp
  );

endinterface

// File: rtl/UART_rcv.sv
// UART receiver, 8N1, samples each bit at mid-period
// rdy rises after the stop bit, held until clr_rdy or next start
module UART_rcv #(
  parameter int BAUD_CLKS = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
);

  localparam int BW = $clog2(BAUD_CLKS + 1);

  logic          rx_ff1;
  logic          rx_ff2;
  logic          busy;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shft;
  logic          start;
  logic          tick;
  logic          done;

  assign start   = !busy && !rx_ff2;
  assign tick    = busy && (baud_cnt == '0);
  assign done    = tick && (bit_cnt == 4'd9);
  assign rx_data = shft;

  // double-flop RX into the clk domain, idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1 <= 1'b1;
      rx_ff2 <= 1'b1;
    end else begin
      rx_ff1 <= RX;
      rx_ff2 <= rx_ff1;
    end
  end

  // bit timing and data shift, start/stop samples not stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shft     <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      baud_cnt <= BW'(BAUD_CLKS / 2);
      bit_cnt  <= '0;
    end else if (tick) begin
      baud_cnt <= BW'(BAUD_CLKS - 1);
      bit_cnt  <= bit_cnt + 4'd1;
      if (bit_cnt != 4'd0 && bit_cnt != 4'd9)
        shft <= {rx_ff2, shft[7:1]};
      if (done)
        busy <= 1'b0;
    end else if (busy) begin
      baud_cnt <= baud_cnt - BW'(1);
    end
  end

  // byte-ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdy <= 1'b0;
    else if (done)
      rdy <= 1'b1;
    else if (clr_rdy || start)
      rdy <= 1'b0;
  end

endmodule

// File: rtl/UART_tx.sv
// UART transmitter, 8N1, TX idles high
// tx_done is a one-cycle pulse at the end of the stop bit
module UART_tx #(
  parameter int BAUD_CLKS = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int BW = $clog2(BAUD_CLKS + 1);

  logic          busy;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shft;

  assign TX = shft[0];

  // frame shifter; reset forces the line high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shft     <= '1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (trmt && !busy) begin
        busy     <= 1'b1;
        shft     <= {1'b1, tx_data, 1'b0};
        baud_cnt <= BW'(BAUD_CLKS - 1);
        bit_cnt  <= '0;
      end else if (busy) begin
        if (baud_cnt == '0) begin
          shft     <= {1'b1, shft[9:1]};
          baud_cnt <= BW'(BAUD_CLKS - 1);
          bit_cnt  <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) begin
            busy    <= 1'b0;
            tx_done <= 1'b1;
          end
        end else begin
          baud_cnt <= baud_cnt - BW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/uart_pkt_assembler.sv
// three-byte packet assembler with inter-byte timeout
// outputs update atomically only when a packet completes
module uart_pkt_assembler
  import uart_cmd_wrapper_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [7:0]  rx_data,
  input  logic        clr_cmd_rdy,
  output logic        clr_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy
);

  localparam int GW = $clog2(TIMEOUT_CLKS + 1);

  rx_state_t     state;
  rx_state_t     nxt_state;
  logic [7:0]    sh_cmd;
  logic [7:0]    sh_hi;
  logic [GW-1:0] gap_cnt;
  logic          counting;
  logic          timeout;
  logic          ld_cmd;
  logic          ld_hi;
  logic          ld_out;

  assign clr_rdy  = rdy;
  assign counting = (state != WAIT_CMD);
  assign timeout  = counting &&
                    (gap_cnt == GW'(TIMEOUT_CLKS));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= WAIT_CMD;
    else
      state <= nxt_state;
  end

  // byte sequencing; a byte wins over a coincident timeout
  always_comb begin
    nxt_state = state;
    ld_cmd    = 1'b0;
    ld_hi     = 1'b0;
    ld_out    = 1'b0;
    unique case (state)
      WAIT_CMD: begin
        if (rdy) begin
          ld_cmd    = 1'b1;
          nxt_state = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (rdy) begin
          ld_hi     = 1'b1;
          nxt_state = WAIT_LO;
        end else if (timeout) begin
          nxt_state = WAIT_CMD;
        end
      end
      WAIT_LO: begin
        if (rdy) begin
          ld_out    = 1'b1;
          nxt_state = WAIT_CMD;
        end else if (timeout) begin
          nxt_state = WAIT_CMD;
        end
      end
      default: nxt_state = WAIT_CMD;
    endcase
  end

  // inter-byte gap counter, idle at zero between packets
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gap_cnt <= '0;
    else if (rdy || !counting || timeout)
      gap_cnt <= '0;
    else
      gap_cnt <= gap_cnt + GW'(1);
  end

  // shadow bytes for the packet in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_cmd <= '0;
      sh_hi  <= '0;
    end else if (ld_cmd) begin
      sh_cmd <= rx_data;
    end else if (ld_hi) begin
      sh_hi <= rx_data;
    end else if (timeout) begin
      sh_cmd <= '0;
      sh_hi  <= '0;
    end
  end

  // visible packet and its ready flag; set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= '0;
      data    <= '0;
      cmd_rdy <= 1'b0;
    end else if (ld_out) begin
      cmd     <= sh_cmd;
      data    <= {sh_hi, rx_data};
      cmd_rdy <= 1'b1;
    end else if (clr_cmd_rdy || ld_cmd) begin
      cmd_rdy <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// UART packet layer: 3-byte commands in, 1-byte responses out
// RX assembly in uart_pkt_assembler, response sequencing here
module uart_cmd_wrapper
  import uart_cmd_wrapper_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 100000,
  parameter int BAUD_CLKS    = 2604
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RX,
  output logic                TX,
  uart_cmd_wrapper_if.master  host
);

  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       clr_rdy;
  logic       tx_done;
  logic       trmt;
  logic       trmt_nxt;
  logic [7:0] tx_data;
  logic       set_sent;
  logic       clr_sent;
  tx_state_t  tx_state;
  tx_state_t  tx_nxt;

  UART_rcv #(
    .BAUD_CLKS(BAUD_CLKS)
  ) u_rcv (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy    (rx_rdy)
  );

  uart_pkt_assembler #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rx_rdy),
    .rx_data    (rx_data),
    .clr_cmd_rdy(host.clr_cmd_rdy),
    .clr_rdy    (clr_rdy),
    .cmd        (host.cmd),
    .data       (host.data),
    .cmd_rdy    (host.cmd_rdy)
  );

  UART_tx #(
    .BAUD_CLKS(BAUD_CLKS)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .trmt   (trmt),
    .tx_data(tx_data),
    .TX     (TX),
    .tx_done(tx_done)
  );

  // response sequencing; requests while busy are dropped
  always_comb begin
    tx_nxt   = tx_state;
    trmt_nxt = 1'b0;
    set_sent = 1'b0;
    clr_sent = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (host.send_resp) begin
          trmt_nxt = 1'b1;
          clr_sent = 1'b1;
          tx_nxt   = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          set_sent = 1'b1;
          tx_nxt   = TX_IDLE;
        end
      end
      default: tx_nxt = TX_IDLE;
    endcase
  end

  // TX state, registered trmt strobe and latched byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      trmt     <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_state <= tx_nxt;
      trmt     <= trmt_nxt;
      if (trmt_nxt)
        tx_data <= host.resp;
    end
  end

  // response-complete flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      host.resp_sent <= 1'b0;
    else if (set_sent)
      host.resp_sent <= 1'b1;
    else if (clr_sent)
      host.resp_sent <= 1'b0;
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// uart_cmd_wrapper bench: bit-banged RX stimulus,
// scoreboard monitors for packets and TX frames
module tb_uart_cmd_wrapper;

  localparam int BAUD = 16;
  localparam int TMO  = 400;

  typedef struct {
    logic [7:0]  c;
    logic [15:0] d;
  } pkt_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic tx;

  int vectors     = 0;
  int miscompares = 0;
  int tx_frames   = 0;

  pkt_t       exp_q[$];
  logic [7:0] exp_tx_q[$];
  pkt_t       cur_p;
  logic       prev_rdy = 1'b0;

  uart_cmd_wrapper_if host_if ();

  uart_cmd_wrapper #(
    .TIMEOUT_CLKS(TMO),
    .BAUD_CLKS   (BAUD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .RX   (rx),
    .TX   (tx),
    .host (host_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h",
               nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (BAUD) @(negedge clk);
    end
    repeat (2 * BAUD) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] a,
                          input logic [7:0] b,
                          input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  task automatic pulse_send(input logic [7:0] r);
    host_if.resp      = r;
    host_if.send_resp = 1'b1;
    @(negedge clk);
    host_if.send_resp = 1'b0;
  endtask

  task automatic wait_sent(input string nm);
    int n;
    n = 0;
    while (!host_if.resp_sent && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(host_if.resp_sent), 32'd1);
  endtask

  // packet monitor: each cmd_rdy rise pops one expectation
  always @(negedge clk) begin
    if (rst_n && host_if.cmd_rdy && !prev_rdy) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pkt: got %h/%h, required none",
                 host_if.cmd, host_if.data);
      end else begin
        cur_p = exp_q.pop_front();
        chk("pkt_cmd", 32'(host_if.cmd), 32'(cur_p.c));
        chk("pkt_data", 32'(host_if.data), 32'(cur_p.d));
      end
    end
    prev_rdy <= host_if.cmd_rdy;
  end

  // TX frame monitor: decode at bit centres
  initial begin
    logic [7:0] b;
    logic       stp;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = tx;
        end
        repeat (BAUD) @(negedge clk);
        stp = tx;
        tx_frames++;
        chk("tx_stop", 32'(stp), 32'd1);
        if (exp_tx_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: got %h, required none", b);
        end else begin
          chk("tx_byte", 32'(b), 32'(exp_tx_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    rx    = 1'b1;
    host_if.clr_cmd_rdy = 1'b0;
    host_if.resp        = 8'h00;
    host_if.send_resp   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_cmd", 32'(host_if.cmd), 32'h00);
    chk("rst_data", 32'(host_if.data), 32'h0000);
    chk("rst_cmd_rdy", 32'(host_if.cmd_rdy), 32'd0);
    chk("rst_resp_sent", 32'(host_if.resp_sent), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // basic packet then acknowledge
    exp_q.push_back('{c: 8'hA5, d: 16'h1234});
    send_pkt(8'hA5, 8'h12, 8'h34);
    chk("p1_rdy", 32'(host_if.cmd_rdy), 32'd1);
    host_if.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    host_if.clr_cmd_rdy = 1'b0;
    chk("p1_clr", 32'(host_if.cmd_rdy), 32'd0);

    // partial packet discarded by timeout
    send_byte(8'h01);
    send_byte(8'hFF);
    chk("partial_cmd", 32'(host_if.cmd), 32'hA5);
    chk("partial_data", 32'(host_if.data), 32'h1234);
    repeat (TMO + 100) @(negedge clk);
    exp_q.push_back('{c: 8'h02, d: 16'h0007});
    send_pkt(8'h02, 8'h00, 8'h07);
    chk("tmo_rdy", 32'(host_if.cmd_rdy), 32'd1);

    // back-to-back packets, no acknowledge
    exp_q.push_back('{c: 8'h33, d: 16'h4455});
    send_byte(8'h33);
    chk("b2b_drop", 32'(host_if.cmd_rdy), 32'd0);
    chk("b2b_hold", 32'(host_if.cmd), 32'h02);
    send_byte(8'h44);
    send_byte(8'h55);
    chk("b2b_rdy", 32'(host_if.cmd_rdy), 32'd1);

    // completion and acknowledge in the same cycle
    exp_q.push_back('{c: 8'h9C, d: 16'h0DEF});
    send_byte(8'h9C);
    send_byte(8'h0D);
    fork
      send_byte(8'hEF);
      begin
        n = 0;
        while (!dut.u_rcv.rdy && n < 400) begin
          @(negedge clk);
          n++;
        end
        if (!dut.u_rcv.rdy) begin
          vectors++;
          miscompares++;
          $display("FAIL sim_wait: got no rdy, required rdy");
        end else begin
          host_if.clr_cmd_rdy = 1'b1;
          @(negedge clk);
          host_if.clr_cmd_rdy = 1'b0;
          chk("sim_set_wins", 32'(host_if.cmd_rdy), 32'd1);
        end
      end
    join

    // response transmit, busy request dropped
    exp_tx_q.push_back(8'h5A);
    pulse_send(8'h5A);
    chk("resp_busy_low", 32'(host_if.resp_sent), 32'd0);
    repeat (20) @(negedge clk);
    pulse_send(8'hC3);
    wait_sent("resp_sent1");
    repeat (300) @(negedge clk);
    chk("tx_frames1", 32'(tx_frames), 32'd1);
    exp_tx_q.push_back(8'h3C);
    pulse_send(8'h3C);
    @(negedge clk);
    chk("resp_cleared", 32'(host_if.resp_sent), 32'd0);
    wait_sent("resp_sent2");
    repeat (40) @(negedge clk);
    chk("tx_frames2", 32'(tx_frames), 32'd2);

    // reset in the middle of a packet
    send_byte(8'h77);
    send_byte(8'h88);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd", 32'(host_if.cmd), 32'h00);
    chk("mid_rst_data", 32'(host_if.data), 32'h0000);
    chk("mid_rst_rdy", 32'(host_if.cmd_rdy), 32'd0);
    chk("mid_rst_sent", 32'(host_if.resp_sent), 32'd0);
    chk("mid_rst_tx", 32'(tx), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.push_back('{c: 8'h10, d: 16'h0001});
    send_pkt(8'h10, 8'h00, 8'h01);
    chk("post_rst_rdy", 32'(host_if.cmd_rdy), 32'd1);

    repeat (10) @(negedge clk);
    chk("pkt_q_empty", 32'(exp_q.size()), 32'd0);
    chk("tx_q_empty", 32'(exp_tx_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
